// File: rtl/tamagotchi_needs_v3_if.sv
// rtl/tamagotchi_needs_v3_if.sv - button inputs and need/mood outputs of the needs engine
interface tamagotchi_needs_v3_if #(
  parameter int NUM_NEEDS = 4,
  parameter int LEVEL_W   = 4
);
  logic                         test_but;
  logic [NUM_NEEDS-1:0]         act;
  logic [NUM_NEEDS*LEVEL_W-1:0] levels;
  logic [1:0]                   pet_state;
  logic [NUM_NEEDS-1:0]         alert;
  logic                         tick;
  logic                         test_mode;

  modport master (
    output test_but, act,
    input  levels, pet_state, alert, tick, test_mode
  );

  modport slave (
    input  test_but, act,
    output levels, pet_state, alert, tick, test_mode
  );
endinterface

// File: rtl/tamagotchi_needs_v3.sv
// rtl/tamagotchi_needs_v3.sv - N-channel pet needs engine with decay, actions and mood FSM (TAMA_TEST_MODE_EN enables accelerated test mode)
module tamagotchi_needs_v3 #(
  parameter int NUM_NEEDS    = 4,
  parameter int LEVEL_W      = 4,
  parameter int DECAY_CYCLES = 50_000_000,
  parameter int TEST_DIV     = 10,
  parameter int ACT_STEP     = 3,
  parameter int NEEDY_TH     = 5,
  parameter int CRIT_TH      = 2,
  parameter int DEAD_TICKS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tamagotchi_needs_v3_if.slave  bus
);

  localparam int PW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int SW = $clog2(DEAD_TICKS + 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_W-1:0] NEEDY_L   = LEVEL_W'(NEEDY_TH);
  localparam logic [LEVEL_W-1:0] CRIT_L    = LEVEL_W'(CRIT_TH);
  localparam logic [LEVEL_W:0]   STEP_L    = (LEVEL_W + 1)'(ACT_STEP);
  localparam logic [PW-1:0]      LAST_NORM = PW'(DECAY_CYCLES - 1);

  typedef enum logic [1:0] {NORMAL = 2'd0, NEEDY = 2'd1, CRITICAL = 2'd2, DEAD = 2'd3} mood_t;

  logic [PW-1:0]                pre_cnt;
  logic [PW-1:0]                last_cnt;
  logic                         tick_q;
  logic                         tb_rise;
  logic [NUM_NEEDS-1:0]         act_q;
  logic [NUM_NEEDS-1:0]         act_rise;
  logic [LEVEL_W-1:0]           level_q [NUM_NEEDS];
  logic [LEVEL_W-1:0]           level_d [NUM_NEEDS];
  logic [NUM_NEEDS*LEVEL_W-1:0] levels_flat;
  logic [LEVEL_W-1:0]           min_lvl;
  logic                         any_zero;
  logic [NUM_NEEDS-1:0]         alert_d;
  logic [NUM_NEEDS-1:0]         alert_q;
  mood_t                        state_q;
  mood_t                        cls;
  logic [SW-1:0]                starve_q;

  // Decrement on tick first, then apply the action step, each saturating
  function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] cur,
                                                    input logic dec, input logic inc);
    logic [LEVEL_W-1:0] after_dec;
    logic [LEVEL_W:0]   sum;
    after_dec = (dec && cur != '0) ? cur - LEVEL_W'(1) : cur;
    sum = {1'b0, after_dec} + STEP_L;
    next_level = inc ? ((sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : sum[LEVEL_W-1:0]) : after_dec;
  endfunction

`ifdef TAMA_TEST_MODE_EN
  localparam logic [PW-1:0] LAST_TEST = PW'(DECAY_CYCLES / TEST_DIV - 1);
  logic tb_q;
  logic test_mode_q;
  assign tb_rise  = bus.test_but & ~tb_q;
  assign last_cnt = test_mode_q ? LAST_TEST : LAST_NORM;
  assign bus.test_mode = test_mode_q;

  // Edge-detect the test button and flip the accelerated-period flag on each press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_q        <= 1'b0;
      test_mode_q <= 1'b0;
    end else begin
      tb_q <= bus.test_but;
      if (tb_rise) test_mode_q <= ~test_mode_q;
    end
  end
`else
  wire unused_test_but = bus.test_but;
  assign tb_rise  = 1'b0;
  assign last_cnt = LAST_NORM;
  assign bus.test_mode = 1'b0;
`endif

  assign act_rise = bus.act & ~act_q;

  // Shared prescaler; a test-mode toggle restarts the period and swallows the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (tb_rise) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (pre_cnt >= last_cnt) begin
      pre_cnt <= '0;
      tick_q  <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick_q  <= 1'b0;
    end
  end

  // Per-channel next level, minimum level, zero detection and alert flags
  always_comb begin
    min_lvl     = level_q[0];
    any_zero    = 1'b0;
    alert_d     = '0;
    levels_flat = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (level_q[i] < min_lvl) min_lvl = level_q[i];
      if (level_q[i] == '0) any_zero = 1'b1;
      alert_d[i] = (level_q[i] <= NEEDY_L);
      levels_flat[i*LEVEL_W +: LEVEL_W] = level_q[i];
      level_d[i] = next_level(level_q[i], tick_q, act_rise[i]);
    end
  end

  assign cls = (min_lvl <= CRIT_L) ? CRITICAL : (min_lvl <= NEEDY_L) ? NEEDY : NORMAL;

  // Level registers and action edge detect; a dead pet's levels are frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= '0;
      for (int i = 0; i < NUM_NEEDS; i++) level_q[i] <= LEVEL_MAX;
    end else begin
      act_q <= bus.act;
      if (state_q != DEAD) begin
        for (int i = 0; i < NUM_NEEDS; i++) level_q[i] <= level_d[i];
      end
    end
  end

  // Mood FSM with starvation counter; DEAD is left only through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      alert_q  <= '0;
    end else begin
      alert_q <= alert_d;
      case (state_q)
        DEAD: state_q <= DEAD;
        CRITICAL: begin
          if (tick_q && any_zero) begin
            if (starve_q == SW'(DEAD_TICKS - 1)) state_q <= DEAD;
            starve_q <= starve_q + SW'(1);
          end else begin
            state_q <= cls;
            if (!any_zero) starve_q <= '0;
          end
        end
        default: begin
          state_q  <= cls;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign bus.levels    = levels_flat;
  assign bus.pet_state = state_q;
  assign bus.alert     = alert_q;
  assign bus.tick      = tick_q;

endmodule

// File: doc/tamagotchi_needs_v3.md
# tamagotchi_needs_v3

Parametrised needs engine for the tamagotchi pet: tracks NUM_NEEDS independent need levels (hunger, health, energy, …) that decay on a shared prescaled tick and are replenished by action buttons. It derives the pet's mood state (NORMAL/NEEDY/CRITICAL/DEAD) and per-need alerts for the display FSM. It generalises the fixed feeding/healing logic of the previous generation to N channels with configurable width, thresholds and an accelerated test-time mode.

## Interface
- NUM_NEEDS, 4, number of need channels (≥1)
- LEVEL_W, 4, bits per level; LEVEL_MAX = 2^LEVEL_W−1
- DECAY_CYCLES, 50_000_000, clock cycles per decay tick in normal mode (≥2)
- TEST_DIV, 10, divisor of the tick period in test mode; test period = DECAY_CYCLES/TEST_DIV (integer, ≥1)
- ACT_STEP, 3, level increment per action (1..LEVEL_MAX)
- NEEDY_TH, 5, level at or below which a need is alerted
- CRIT_TH, 2, level at or below which the pet is CRITICAL (< NEEDY_TH)
- DEAD_TICKS, 8, consecutive starving ticks in CRITICAL before DEAD
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  asynchronous, active-high reset
- testBut  in  1  test-mode toggle button (synchronous, debounced upstream)
- act  in  NUM_NEEDS  action buttons, bit i replenishes need i (level, debounced upstream)
- levels  out  NUM_NEEDS*LEVEL_W  need levels, channel i at [i*LEVEL_W +: LEVEL_W]
- pet_state  out  2  0=NORMAL, 1=NEEDY, 2=CRITICAL, 3=DEAD
- alert  out  NUM_NEEDS  bit i = levels[i] ≤ NEEDY_TH
- tick  out  1  one-cycle decay-tick strobe
- test_mode  out  1  current test-mode flag

## Operation
- Reset values: every level = LEVEL_MAX, pet_state=0, alert=0, tick=0, test_mode=0, prescaler=0, starve counter=0, edge-detect registers=0.
- Prescaler: counts 0..P−1, P = DECAY_CYCLES (or test period when test_mode=1); tick=1 for the one cycle after count reaches P−1, count wraps to 0.
- Rising edge of testBut toggles test_mode and clears the prescaler the same cycle; no tick is emitted on that cycle.
- Actions: act registered each cycle; rising edge on act[i] (current 1, previous 0) adds ACT_STEP to level i, saturating at LEVEL_MAX. Holding act high yields exactly one increment. Multiple bits rising together each apply to their own channel.
- Decay: on tick, every level decrements by 1, saturating at 0.
- Same-cycle tick and action on one channel: decrement first (saturate at 0), then increment (saturate at LEVEL_MAX).
- Mood FSM, evaluated each cycle on registered levels, m = minimum level:
  - NORMAL/NEEDY/CRITICAL: m ≤ CRIT_TH → CRITICAL; else m ≤ NEEDY_TH → NEEDY; else NORMAL (recovery in any direction allowed).
  - In CRITICAL: on each tick with any level = 0, starve counter +1; any cycle with no zero level clears it. Counter reaching DEAD_TICKS → DEAD. Leaving CRITICAL clears the counter.
  - DEAD: absorbing; levels frozen, act ignored, tick and testBut keep operating; only Rst exits.

## Timing
- Level update visible one cycle after the clock edge that samples the act rising edge or asserts tick.
- alert and pet_state are registered from levels: one further cycle of latency.
- Rst asserts all outputs to reset values immediately (asynchronous), mid-tick or mid-action; release synchronous to Clk; first tick P cycles after release.
- Prescaler width = clog2(DECAY_CYCLES); no overflow at any parameter value.

## Configuration
- TAMA_TEST_MODE_EN defined: testBut toggles test_mode and the accelerated period as above.
- Undefined: testBut ignored (port kept), test_mode tied 0, period always DECAY_CYCLES; test-period logic not synthesised.

## Test plan
Bench params: NUM_NEEDS=2, LEVEL_W=4, DECAY_CYCLES=20, TEST_DIV=4, ACT_STEP=3, NEEDY_TH=5, CRIT_TH=2, DEAD_TICKS=3.
- Reset release → levels 15/15, pet_state 0, alert 00; first tick 20 cycles later, levels 14/14; ticks every 20 cycles.
- act[0] held 50 cycles at level 10 → level 13 once only; from 14 → 15 (saturation).
- testBut pulse (macro on) → test_mode 1, ticks every 5 cycles; second pulse → back to 20; macro off → period stays 20.
- Free decay → at level 5 pet_state 1, alert 11; at 2 pet_state 2; at 0 plus 3 ticks pet_state 3; subsequent act ignored, levels stay 0.
- tick and act[1] rising same cycle: level 0 → 3; level 15 → 15.
- Rst pulse mid-operation in DEAD with test_mode 1 → immediate levels 15/15, pet_state 0, test_mode 0, prescaler restarts.
